// File: rtl/sha_work_loader_pkg.sv
// Shared definitions for the SHA work loader: FSM states, framing constants
// and the bit positions of each work field inside the assembled frame image.
package sha_work_loader_pkg;

    localparam int         FRAME_BYTES = 80;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         SHADOW_BITS = FRAME_BYTES * 8;
    localparam int         COUNT_BITS  = 7;

    // LSB position of each field in the 640-bit image (first byte received is the MSB)
    localparam int DIGEST_INITIAL_LSB = 384;
    localparam int DIGEST_IN_LSB      = 128;
    localparam int MERKLE_LSB         = 96;
    localparam int TIME_LSB           = 64;
    localparam int TARGET_LSB         = 32;
    localparam int NONCE_LSB          = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ARM     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FOUND   = 3'd5
    } state_t;

endpackage

// File: rtl/sha_work_shifter.sv
// Byte-wide shift register that assembles a work frame, with a saturating byte
// counter and a commit register bank that drives the hasher's work inputs.
module sha_work_shifter
    import sha_work_loader_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         clear,
    input  logic         shift_en,
    input  logic [7:0]   byte_in,
    input  logic         commit,
    output logic         at_last,
    output logic [255:0] digest_intial_o,
    output logic [255:0] digest_in_o,
    output logic [31:0]  merkle_o,
    output logic [31:0]  time_o,
    output logic [31:0]  target_o,
    output logic [31:0]  nonce_o
);

    localparam logic [COUNT_BITS-1:0] LAST_INDEX = COUNT_BITS'(FRAME_BYTES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX  = '1;

    logic [SHADOW_BITS-1:0] shadow_q, shadow_d;
    logic [COUNT_BITS-1:0]  count_q, count_d;
    logic [255:0]           digest_intial_q, digest_intial_d;
    logic [255:0]           digest_in_q, digest_in_d;
    logic [31:0]            merkle_q, merkle_d;
    logic [31:0]            time_q, time_d;
    logic [31:0]            target_q, target_d;
    logic [31:0]            nonce_q, nonce_d;

    // The byte being accepted now is the final payload byte of the frame
    assign at_last = (count_q == LAST_INDEX);

    // Shift incoming bytes in from the bottom; clear discards a partial frame
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (clear) begin
            shadow_d = '0;
            count_d  = '0;
        end else if (shift_en) begin
            shadow_d = {shadow_q[SHADOW_BITS-9:0], byte_in};
            if (count_q != COUNT_MAX) begin
                count_d = count_q + COUNT_BITS'(1);
            end
        end
    end

    // Copy the assembled image onto the hasher-facing fields only on commit
    always_comb begin
        digest_intial_d = digest_intial_q;
        digest_in_d     = digest_in_q;
        merkle_d        = merkle_q;
        time_d          = time_q;
        target_d        = target_q;
        nonce_d         = nonce_q;
        if (commit) begin
            digest_intial_d = shadow_q[DIGEST_INITIAL_LSB +: 256];
            digest_in_d     = shadow_q[DIGEST_IN_LSB +: 256];
            merkle_d        = shadow_q[MERKLE_LSB +: 32];
            time_d          = shadow_q[TIME_LSB +: 32];
            target_d        = shadow_q[TARGET_LSB +: 32];
            nonce_d         = shadow_q[NONCE_LSB +: 32];
        end
    end

    // State registers for the shadow image, counter and committed fields
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_q        <= '0;
            count_q         <= '0;
            digest_intial_q <= '0;
            digest_in_q     <= '0;
            merkle_q        <= '0;
            time_q          <= '0;
            target_q        <= '0;
            nonce_q         <= '0;
        end else begin
            shadow_q        <= shadow_d;
            count_q         <= count_d;
            digest_intial_q <= digest_intial_d;
            digest_in_q     <= digest_in_d;
            merkle_q        <= merkle_d;
            time_q          <= time_d;
            target_q        <= target_d;
            nonce_q         <= nonce_d;
        end
    end

    assign digest_intial_o = digest_intial_q;
    assign digest_in_o     = digest_in_q;
    assign merkle_o        = merkle_q;
    assign time_o          = time_q;
    assign target_o        = target_q;
    assign nonce_o         = nonce_q;

endmodule

// File: rtl/sha_work_loader.sv
// Feeds framed work units to the SHA hasher: assembles the frame, holds the
// hasher in reset while loading, releases and enables it, then latches the
// solution it reports. Hasher control outputs are registered from the next
// state, so they lag the FSM by one cycle (rst_n rises as RUN is entered).
module sha_work_loader
    import sha_work_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         hasher_rst_n,
    output logic         hasher_write_en,
    output logic [255:0] digest_intial_o,
    output logic [255:0] digest_in_o,
    output logic [31:0]  merkle_o,
    output logic [31:0]  time_o,
    output logic [31:0]  target_o,
    output logic [31:0]  nonce_o,
    input  logic         hasher_valid,
    input  logic [31:0]  hasher_time,
    input  logic [31:0]  hasher_nonce,
    output logic         found,
    output logic [31:0]  found_time,
    output logic [31:0]  found_nonce,
    output logic         busy,
    output logic         frame_err
);

    localparam int                    TIMER_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_BITS-1:0] TIMER_LIMIT = TIMER_BITS'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic                  hasher_rst_n_q, hasher_rst_n_d;
    logic                  write_en_q, write_en_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  found_q, found_d;
    logic [31:0]           found_time_q, found_time_d;
    logic [31:0]           found_nonce_q, found_nonce_d;

    logic transfer;
    logic is_header;
    logic shift_en;
    logic clear;
    logic commit;
    logic at_last;

    assign rx_ready  = (state_q != ST_ARM) && (state_q != ST_RELEASE);
    assign transfer  = rx_valid && rx_ready;
    assign is_header = (rx_data == HEADER_BYTE);

    sha_work_shifter u_shifter (
        .CLK             (CLK),
        .RST             (RST),
        .clear           (clear),
        .shift_en        (shift_en),
        .byte_in         (rx_data),
        .commit          (commit),
        .at_last         (at_last),
        .digest_intial_o (digest_intial_o),
        .digest_in_o     (digest_in_o),
        .merkle_o        (merkle_o),
        .time_o          (time_o),
        .target_o        (target_o),
        .nonce_o         (nonce_o)
    );

    // Next-state, frame timer, solution latch and registered hasher controls
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        frame_err_d   = 1'b0;
        shift_en      = 1'b0;
        clear         = 1'b0;
        commit        = 1'b0;
        found_d       = found_q;
        found_time_d  = found_time_q;
        found_nonce_d = found_nonce_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (transfer && is_header) begin
                    clear   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (transfer) begin
                    shift_en = 1'b1;
                    timer_d  = '0;
                    if (at_last) begin
                        state_d = ST_ARM;
                    end
                end else if (timer_q == TIMER_LIMIT) begin
                    frame_err_d = 1'b1;
                    clear       = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_BITS'(1);
                end
            end
            ST_ARM: begin
                commit        = 1'b1;
                found_d       = 1'b0;
                found_time_d  = '0;
                found_nonce_d = '0;
                state_d       = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hasher_valid) begin
                    found_d       = 1'b1;
                    found_time_d  = hasher_time;
                    found_nonce_d = hasher_nonce;
                    state_d       = ST_FOUND;
                end
                if (transfer && is_header) begin
                    clear   = 1'b1;
                    timer_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_FOUND: begin
                if (transfer && is_header) begin
                    clear   = 1'b1;
                    timer_d = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hasher_rst_n_d = (state_d == ST_RUN) || (state_d == ST_FOUND);
        write_en_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
        busy_d         = write_en_d;
    end

    // State and output registers; reset holds the hasher in reset immediately
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            hasher_rst_n_q <= 1'b0;
            write_en_q     <= 1'b0;
            busy_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            found_q        <= 1'b0;
            found_time_q   <= '0;
            found_nonce_q  <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            hasher_rst_n_q <= hasher_rst_n_d;
            write_en_q     <= write_en_d;
            busy_q         <= busy_d;
            frame_err_q    <= frame_err_d;
            found_q        <= found_d;
            found_time_q   <= found_time_d;
            found_nonce_q  <= found_nonce_d;
        end
    end

    assign hasher_rst_n    = hasher_rst_n_q;
    assign hasher_write_en = write_en_q;
    assign busy            = busy_q;
    assign frame_err       = frame_err_q;
    assign found           = found_q;
    assign found_time      = found_time_q;
    assign found_nonce     = found_nonce_q;

endmodule
